// File: rtl/fx68k_pkg.sv
// Shared definitions for the fx68k bus-side helpers: responder FSM states,
// CPU-space constants and counter sizing.
package fx68k_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK,
        BERR,
        IACK
    } resp_state_t;

    localparam logic [2:0] FC_CPU_SPACE     = 3'b111;
    localparam logic [3:0] IACK_ADDR_NIBBLE = 4'hF;

    // Enough bits to hold the larger of the two limits without wrapping.
    function automatic int counter_width(input int timeout, input int waits);
        int max_count;
        max_count = (timeout > waits) ? timeout : waits;
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/fx68k_resp_timer.sv
// Saturating cycle counter shared by the access timeout and the wait-state
// delay of the bus responder.
module fx68k_resp_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fx68k_bus_responder.sv
// Answers fx68k bus cycles: bridges memory cycles to a simple req/ready port,
// inserts wait states, raises bus error on timeout and autovectors IACK cycles.
module fx68k_bus_responder
    import fx68k_pkg::*;
#(
    parameter int WAIT_STATES  = 0,
    parameter int BERR_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        extReset,
    input  logic        ASn,
    input  logic        UDSn,
    input  logic        LDSn,
    input  logic        eRWn,
    input  logic [2:0]  FC,
    input  logic [23:1] eab,
    input  logic [15:0] oEdb,
    output logic        DTACKn,
    output logic        BERRn,
    output logic        VPAn,
    output logic [15:0] iEdb,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:1] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata
);

    localparam int CW = counter_width(BERR_TIMEOUT, WAIT_STATES);

    resp_state_t   state;
    logic [CW-1:0] count;
    logic          timer_clear;
    logic          timer_enable;
    logic          aborted;
    logic          armed;
    logic          cycle_start;
    logic          is_iack;

    assign cycle_start  = armed && !ASn && (!UDSn || !LDSn);
    assign is_iack      = (FC == FC_CPU_SPACE) && (eab[19:16] == IACK_ADDR_NIBBLE);
    assign timer_clear  = (state == IDLE) || ((state == ACCESS) && mem_ready);
    assign timer_enable = (state == ACCESS) || (state == WAIT);

    fx68k_resp_timer #(.WIDTH(CW)) u_timer (
        .clk    (clk),
        .rst    (extReset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .count  (count)
    );

    // armed only sets once ASn=1 is seen, so a strobe left low across reset
    // or after a completed cycle cannot start a new one.
    always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
            state     <= IDLE;
            DTACKn    <= 1'b1;
            BERRn     <= 1'b1;
            VPAn      <= 1'b1;
            iEdb      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            aborted   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            if (ASn) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    if (cycle_start) begin
                        armed <= 1'b0;
                        if (is_iack) begin
                            VPAn  <= 1'b0;
                            state <= IACK;
                        end else begin
                            mem_addr  <= eab;
                            mem_we    <= ~eRWn;
                            mem_be    <= {~UDSn, ~LDSn};
                            mem_wdata <= oEdb;
                            mem_req   <= 1'b1;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (ASn) begin
                        aborted <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            iEdb <= mem_rdata;
                        end
                        if (aborted || ASn) begin
                            state <= IDLE;
                        end else if (WAIT_STATES == 0) begin
                            DTACKn <= 1'b0;
                            state  <= ACK;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (count == CW'(BERR_TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        if (aborted || ASn) begin
                            state <= IDLE;
                        end else begin
                            BERRn <= 1'b0;
                            state <= BERR;
                        end
                    end
                end
                WAIT: begin
                    if (ASn) begin
                        state <= IDLE;
                    end else if (count == CW'(WAIT_STATES - 1)) begin
                        DTACKn <= 1'b0;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    if (ASn) begin
                        DTACKn <= 1'b1;
                        state  <= IDLE;
                    end
                end
                BERR: begin
                    if (ASn) begin
                        BERRn <= 1'b1;
                        state <= IDLE;
                    end
                end
                IACK: begin
                    if (ASn) begin
                        VPAn  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx68k_bus_responder.sv
// Directed bench for fx68k_bus_responder: one instance with no wait states
// (a) and one with three wait states (b), both driven by the same CPU bus.
module tb_fx68k_bus_responder;
    import fx68k_pkg::*;

    logic        clk = 1'b0;
    logic        extReset;
    logic        ASn, UDSn, LDSn, eRWn;
    logic [2:0]  FC;
    logic [23:1] eab;
    logic [15:0] oEdb;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    logic        dtack_a, berr_a, vpa_a, req_a, we_a;
    logic [15:0] iedb_a, wdata_a;
    logic [23:1] addr_a;
    logic [1:0]  be_a;
    logic        dtack_b, berr_b, vpa_b, req_b, we_b;
    logic [15:0] iedb_b, wdata_b;
    logic [23:1] addr_b;
    logic [1:0]  be_b;

    logic [3:0]  stat_a, stat_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign stat_a = {dtack_a, berr_a, vpa_a, req_a};
    assign stat_b = {dtack_b, berr_b, vpa_b, req_b};

    always #5 clk = ~clk;

    fx68k_bus_responder #(.WAIT_STATES(0), .BERR_TIMEOUT(64)) dut_a (
        .clk(clk), .extReset(extReset), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
        .eRWn(eRWn), .FC(FC), .eab(eab), .oEdb(oEdb),
        .DTACKn(dtack_a), .BERRn(berr_a), .VPAn(vpa_a), .iEdb(iedb_a),
        .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_be(be_a),
        .mem_wdata(wdata_a), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    fx68k_bus_responder #(.WAIT_STATES(3), .BERR_TIMEOUT(64)) dut_b (
        .clk(clk), .extReset(extReset), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
        .eRWn(eRWn), .FC(FC), .eab(eab), .oEdb(oEdb),
        .DTACKn(dtack_b), .BERRn(berr_b), .VPAn(vpa_b), .iEdb(iedb_b),
        .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_be(be_b),
        .mem_wdata(wdata_b), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // At most one of the three response strobes may be low at any time.
    always @(negedge clk) begin
        if (!extReset) begin
            n_cmp++;
            if ($countones({~dtack_a, ~berr_a, ~vpa_a}) > 1 ||
                $countones({~dtack_b, ~berr_b, ~vpa_b}) > 1) begin
                n_bad++;
                $display("[TB] FAIL strobe_exclusive: a=%b b=%b at %0t", stat_a, stat_b, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_start(input logic rw, input logic uds, input logic lds,
                             input logic [2:0] fc, input logic [23:1] addr,
                             input logic [15:0] data);
        ASn  = 1'b0;
        UDSn = uds;
        LDSn = lds;
        eRWn = rw;
        FC   = fc;
        eab  = addr;
        oEdb = data;
    endtask

    task automatic cpu_release();
        ASn  = 1'b1;
        UDSn = 1'b1;
        LDSn = 1'b1;
        eRWn = 1'b1;
    endtask

    task automatic test_reset();
        extReset = 1'b1;
        #1;
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL reset_status: a=%b b=%b want 1110", stat_a, stat_b);
        end
        n_cmp++;
        if ({we_a, be_a, addr_a, wdata_a, iedb_a} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_mem: we=%b be=%b addr=%h wdata=%h iedb=%h want 0",
                     we_a, be_a, addr_a, wdata_a, iedb_a);
        end
        @(negedge clk);
        extReset = 1'b0;
        tick(2);
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL reset_idle: a=%b b=%b want 1110", stat_a, stat_b);
        end
    endtask

    task automatic test_read();
        cpu_start(1'b1, 1'b0, 1'b0, 3'b101, 23'h000080, 16'h0000);
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1111 || addr_a !== 23'h000080 || be_a !== 2'b11 || we_a !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL read_req: stat=%b addr=%h be=%b we=%b want 1111/000080/11/0",
                     stat_a, addr_a, be_a, we_a);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        tick(1);
        mem_ready = 1'b0;
        n_cmp++;
        if (stat_a !== 4'b0110 || iedb_a !== 16'hBEEF) begin
            n_bad++;
            $display("[TB] FAIL read_ack_ws0: stat=%b iedb=%h want 0110/beef", stat_a, iedb_a);
        end
        n_cmp++;
        if (stat_b !== 4'b1110 || iedb_b !== 16'hBEEF) begin
            n_bad++;
            $display("[TB] FAIL read_wait_ws3: stat=%b iedb=%h want 1110/beef", stat_b, iedb_b);
        end
        tick(2);
        n_cmp++;
        if (dtack_b !== 1'b1 || dtack_a !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL read_ws3_early: dtack_b=%b dtack_a=%b want 1/0", dtack_b, dtack_a);
        end
        tick(1);
        n_cmp++;
        if (dtack_b !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL read_ws3_ack: dtack_b=%b want 0", dtack_b);
        end
        cpu_release();
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL read_release: a=%b b=%b want 1110", stat_a, stat_b);
        end
    endtask

    task automatic test_write_byte();
        cpu_start(1'b0, 1'b1, 1'b0, 3'b001, 23'h012345, 16'h00A5);
        tick(1);
        n_cmp++;
        if (be_b !== 2'b01 || we_b !== 1'b1 || wdata_b !== 16'h00A5 ||
            addr_b !== 23'h012345 || req_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL write_latch: be=%b we=%b wdata=%h addr=%h req=%b want 01/1/00a5/012345/1",
                     be_b, we_b, wdata_b, addr_b, req_b);
        end
        tick(2);
        n_cmp++;
        if (req_b !== 1'b1 || dtack_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL write_hold_req: req=%b dtack=%b want 1/1", req_b, dtack_b);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        tick(1);
        mem_ready = 1'b0;
        n_cmp++;
        if (req_b !== 1'b0 || dtack_b !== 1'b1 || iedb_b !== 16'hBEEF || dtack_a !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL write_ready: req=%b dtack_b=%b iedb=%h dtack_a=%b want 0/1/beef/0",
                     req_b, dtack_b, iedb_b, dtack_a);
        end
        tick(2);
        n_cmp++;
        if (dtack_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL write_ws3_early: dtack_b=%b want 1", dtack_b);
        end
        tick(1);
        n_cmp++;
        if (dtack_b !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL write_ws3_ack: dtack_b=%b want 0", dtack_b);
        end
        cpu_release();
        tick(1);
    endtask

    task automatic test_timeout();
        cpu_start(1'b1, 1'b0, 1'b0, 3'b101, 23'h7FFF00, 16'h0000);
        tick(64);
        n_cmp++;
        if (stat_a !== 4'b1111 || stat_b !== 4'b1111) begin
            n_bad++;
            $display("[TB] FAIL timeout_before: a=%b b=%b want 1111", stat_a, stat_b);
        end
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1010 || stat_b !== 4'b1010) begin
            n_bad++;
            $display("[TB] FAIL timeout_berr: a=%b b=%b want 1010", stat_a, stat_b);
        end
        tick(3);
        n_cmp++;
        if (stat_a !== 4'b1010) begin
            n_bad++;
            $display("[TB] FAIL timeout_hold: a=%b want 1010", stat_a);
        end
        cpu_release();
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL timeout_release: a=%b b=%b want 1110", stat_a, stat_b);
        end
    endtask

    task automatic test_iack();
        cpu_start(1'b1, 1'b1, 1'b0, 3'b111, {4'h0, 4'hF, 15'h0003}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_cmp++;
            if (stat_a !== 4'b1100 || stat_b !== 4'b1100) begin
                n_bad++;
                $display("[TB] FAIL iack_vpa[%0d]: a=%b b=%b want 1100", i, stat_a, stat_b);
            end
        end
        cpu_release();
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL iack_release: a=%b want 1110", stat_a);
        end
        cpu_start(1'b1, 1'b1, 1'b0, 3'b111, {4'h0, 4'hE, 15'h0003}, 16'h0000);
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1111) begin
            n_bad++;
            $display("[TB] FAIL iack_nibble_e_is_mem: a=%b want 1111", stat_a);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h5A5A;
        tick(1);
        mem_ready = 1'b0;
        cpu_release();
        tick(1);
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110 || iedb_a !== 16'h5A5A) begin
            n_bad++;
            $display("[TB] FAIL wait_abort: a=%b b=%b iedb=%h want 1110/1110/5a5a", stat_a, stat_b, iedb_a);
        end
        tick(4);
        n_cmp++;
        if (dtack_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL wait_abort_late: dtack_b=%b want 1", dtack_b);
        end
    endtask

    task automatic test_abort();
        cpu_start(1'b1, 1'b0, 1'b0, 3'b110, 23'h000200, 16'h0000);
        tick(1);
        cpu_release();
        tick(2);
        n_cmp++;
        if (stat_a !== 4'b1111 || stat_b !== 4'b1111) begin
            n_bad++;
            $display("[TB] FAIL abort_still_req: a=%b b=%b want 1111", stat_a, stat_b);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        tick(1);
        mem_ready = 1'b0;
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110 || iedb_a !== 16'h1234) begin
            n_bad++;
            $display("[TB] FAIL abort_done: a=%b b=%b iedb=%h want 1110/1110/1234", stat_a, stat_b, iedb_a);
        end
        tick(4);
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL abort_no_ack: a=%b b=%b want 1110", stat_a, stat_b);
        end
    endtask

    task automatic test_back_to_back();
        cpu_start(1'b1, 1'b0, 1'b0, 3'b101, 23'h000010, 16'h0000);
        tick(1);
        mem_ready = 1'b1;
        mem_rdata = 16'h1111;
        tick(1);
        mem_ready = 1'b0;
        cpu_release();
        tick(1);
        cpu_start(1'b1, 1'b0, 1'b0, 3'b101, 23'h000020, 16'h0000);
        tick(1);
        n_cmp++;
        if (req_a !== 1'b1 || addr_a !== 23'h000020 || iedb_a !== 16'h1111) begin
            n_bad++;
            $display("[TB] FAIL b2b_second_req: req=%b addr=%h iedb=%h want 1/000020/1111", req_a, addr_a, iedb_a);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h2222;
        tick(1);
        mem_ready = 1'b0;
        n_cmp++;
        if (stat_a !== 4'b0110 || iedb_a !== 16'h2222) begin
            n_bad++;
            $display("[TB] FAIL b2b_second_ack: stat=%b iedb=%h want 0110/2222", stat_a, iedb_a);
        end
        cpu_release();
        tick(5);
    endtask

    task automatic test_reset_in_ack();
        cpu_start(1'b1, 1'b0, 1'b0, 3'b101, 23'h000030, 16'h0000);
        tick(1);
        mem_ready = 1'b1;
        mem_rdata = 16'h3333;
        tick(1);
        mem_ready = 1'b0;
        #2;
        extReset = 1'b1;
        #1;
        n_cmp++;
        if (stat_a !== 4'b1110 || dut_a.state !== IDLE || iedb_a !== 16'h0000 || addr_a !== 23'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_in_ack: stat=%b state=%0d iedb=%h addr=%h want 1110/IDLE/0/0",
                     stat_a, dut_a.state, iedb_a, addr_a);
        end
        @(negedge clk);
        extReset = 1'b0;
        tick(3);
        n_cmp++;
        if (stat_a !== 4'b1110 || stat_b !== 4'b1110) begin
            n_bad++;
            $display("[TB] FAIL reset_no_restart: a=%b b=%b want 1110", stat_a, stat_b);
        end
        ASn = 1'b1;
        tick(1);
        ASn = 1'b0;
        tick(1);
        n_cmp++;
        if (req_a !== 1'b1 || req_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_new_cycle: req_a=%b req_b=%b want 1/1", req_a, req_b);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h4444;
        tick(1);
        mem_ready = 1'b0;
        cpu_release();
        tick(2);
    endtask

    initial begin
        extReset  = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        FC        = 3'b000;
        eab       = '0;
        oEdb      = 16'h0000;
        cpu_release();
        test_reset();
        test_read();
        test_write_byte();
        test_timeout();
        test_iack();
        test_abort();
        test_back_to_back();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
